// File: rtl/seq_generator.sv
// seq_generator: serial pattern generator.
// On an accepted start it latches a PAT_W-bit pattern and a repeat count.
// It then shifts the pattern out MSB first, count times, and pulses done
// after the last bit.
// Optional build macro SEQ_GENERATOR_GAP_EN: when defined, one idle GAP cycle
// separates consecutive repetitions; when undefined, repetitions run
// back-to-back.
// Reset is asynchronous and active-low.

module seq_generator #(
  parameter int PAT_W = 4,
  parameter int REP_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [REP_W-1:0] count,
  output logic             dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = (PAT_W > 2) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_W - 1);
  localparam logic [REP_W-1:0] ONE_REP  = REP_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
`ifdef SEQ_GENERATOR_GAP_EN
    GAP,
`endif
    DONE
  } state_t;

  state_t           state;
  logic [PAT_W-1:0] patReg;
  logic [PAT_W-1:0] shiftReg;
  logic [REP_W-1:0] repCnt;
  logic [IDX_W-1:0] bitIdx;

  // Single Moore FSM: every output is a flop loaded with the value it must show next cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      patReg     <= '0;
      shiftReg   <= '0;
      repCnt     <= '0;
      bitIdx     <= '0;
      dout       <= 1'b0;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start && (count != '0)) begin
            patReg     <= pattern;
            shiftReg   <= pattern << 1;
            repCnt     <= count;
            bitIdx     <= LAST_IDX;
            dout       <= pattern[PAT_W-1];
            dout_valid <= 1'b1;
            busy       <= 1'b1;
            state      <= SHIFT;
          end else begin
            dout       <= 1'b0;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
          end
        end

        SHIFT: begin
          if (bitIdx != '0) begin
            dout       <= shiftReg[PAT_W-1];
            shiftReg   <= shiftReg << 1;
            bitIdx     <= bitIdx - IDX_W'(1);
            dout_valid <= 1'b1;
            busy       <= 1'b1;
          end else if (repCnt > ONE_REP) begin
            repCnt <= repCnt - ONE_REP;
            bitIdx <= LAST_IDX;
            busy   <= 1'b1;
`ifdef SEQ_GENERATOR_GAP_EN
            shiftReg   <= patReg;
            dout       <= 1'b0;
            dout_valid <= 1'b0;
            state      <= GAP;
`else
            shiftReg   <= patReg << 1;
            dout       <= patReg[PAT_W-1];
            dout_valid <= 1'b1;
`endif
          end else begin
            dout       <= 1'b0;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
            state      <= DONE;
          end
        end

`ifdef SEQ_GENERATOR_GAP_EN
        GAP: begin
          shiftReg   <= patReg << 1;
          dout       <= patReg[PAT_W-1];
          dout_valid <= 1'b1;
          busy       <= 1'b1;
          state      <= SHIFT;
        end
`endif

        DONE: begin
          dout       <= 1'b0;
          dout_valid <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
          state      <= IDLE;
        end

        default: begin
          dout       <= 1'b0;
          dout_valid <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_generator.sv
// tb_seq_generator: directed bench for seq_generator.
// A queue holds the expected {dout, dout_valid, busy, done} vector for each
// upcoming cycle. Every cycle pops one vector and asserts it against the DUT.
// An empty queue means the DUT should be idle with all outputs 0.

module tb_seq_generator;

  localparam int PAT_W = 4;
  localparam int REP_W = 4;
`ifdef SEQ_GENERATOR_GAP_EN
  localparam bit GAP_ON = 1'b1;
`else
  localparam bit GAP_ON = 1'b0;
`endif

  logic             clk;
  logic             reset;
  logic             start;
  logic [PAT_W-1:0] pattern;
  logic [REP_W-1:0] count;
  logic             dout;
  logic             dout_valid;
  logic             busy;
  logic             done;

  logic [3:0] expQ[$];
  logic       lastWasDone;
  int         checks;
  int         errors;

  seq_generator #(.PAT_W(PAT_W), .REP_W(REP_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .pattern   (pattern),
    .count     (count),
    .dout      (dout),
    .dout_valid(dout_valid),
    .busy      (busy),
    .done      (done)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Queue the expected per-cycle outputs of one accepted transfer, done cycle included
  task automatic pushTransfer(input logic [PAT_W-1:0] pat, input logic [REP_W-1:0] cnt);
    for (int r = 0; r < int'(cnt); r++) begin
      for (int b = PAT_W - 1; b >= 0; b--) expQ.push_back({pat[b], 1'b1, 1'b1, 1'b0});
      if (GAP_ON && (r != int'(cnt) - 1)) expQ.push_back(4'b0010);
    end
    expQ.push_back(4'b0001);
  endtask

  // Compare the DUT outputs with the next expected vector, or with all-zero when idle
  task automatic checkOutput(input string tag);
    logic [3:0] exp;
    logic [3:0] obs;
    exp = (expQ.size() > 0) ? expQ.pop_front() : 4'b0000;
    lastWasDone = (exp == 4'b0001);
    obs = {dout, dout_valid, busy, done};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s t=%0t {dout,valid,busy,done} observed=%b expected=%b", tag, $time, obs, exp);
    end
  endtask

  // One cycle: check this cycle's outputs, then drive inputs for the next rising edge
  task automatic applyStimulus(input string tag, input logic s,
                               input logic [PAT_W-1:0] pat, input logic [REP_W-1:0] cnt);
    @(negedge clk);
    checkOutput(tag);
    start   = s;
    pattern = pat;
    count   = cnt;
    if (s && (cnt != '0) && (expQ.size() == 0) && !lastWasDone) pushTransfer(pat, cnt);
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    lastWasDone = 1'b0;
    reset       = 1'b0;
    start       = 1'b0;
    pattern     = '0;
    count       = '0;

    // Outputs are zero under reset before any clock edge
    #2;
    checkOutput("reset_state");
    @(negedge clk);
    reset = 1'b1;

    // Single repetition of 1101
    applyStimulus("idle0", 1'b0, 4'b0000, 4'd0);
    applyStimulus("single_start", 1'b1, 4'b1101, 4'd1);
    for (int i = 0; i < 8; i++) applyStimulus("single", 1'b0, 4'($urandom), 4'($urandom));

    // Three repetitions; pattern/count wiggle after acceptance must not matter
    applyStimulus("rep3_start", 1'b1, 4'b1101, 4'd3);
    for (int i = 0; i < 18; i++) applyStimulus("rep3", 1'b0, 4'($urandom), 4'($urandom));

    // count=0 start is ignored
    for (int i = 0; i < 10; i++) applyStimulus("count0", 1'b1, 4'b1111, 4'd0);
    applyStimulus("count0_end", 1'b0, 4'b0000, 4'd0);

    // Re-pulsed start mid-transfer is ignored
    applyStimulus("repulse_start", 1'b1, 4'b1101, 4'd2);
    applyStimulus("repulse", 1'b0, 4'b1101, 4'd2);
    applyStimulus("repulse_again", 1'b1, 4'b0000, 4'd2);
    for (int i = 0; i < 14; i++) applyStimulus("repulse", 1'b0, 4'b0000, 4'd2);

    // Asynchronous reset in the middle of a count=2 transfer
    applyStimulus("abort_start", 1'b1, 4'b1101, 4'd2);
    applyStimulus("abort", 1'b0, 4'b1101, 4'd2);
    applyStimulus("abort", 1'b0, 4'b1101, 4'd2);
    applyStimulus("abort", 1'b0, 4'b1101, 4'd2);
    #2;
    reset = 1'b0;
    expQ.delete();
    lastWasDone = 1'b0;
    #1;
    checkOutput("abort_async");
    @(negedge clk);
    checkOutput("abort_held");
    reset = 1'b1;
    applyStimulus("post_reset_idle", 1'b0, 4'b0000, 4'd0);
    applyStimulus("post_reset_start", 1'b1, 4'b1011, 4'd1);
    for (int i = 0; i < 8; i++) applyStimulus("post_reset", 1'b0, 4'b0000, 4'd0);

    // Maximum repeat count
    applyStimulus("maxcnt_start", 1'b1, 4'b1001, 4'd15);
    for (int i = 0; i < 80; i++) applyStimulus("maxcnt", 1'b0, 4'($urandom), 4'($urandom));

    // start held high: back-to-back transfers with one DONE and one IDLE cycle between
    for (int i = 0; i < 25; i++) applyStimulus("held_start", 1'b1, 4'b0110, 4'd1);
    applyStimulus("held_release", 1'b0, 4'b0000, 4'd0);

    // Drain anything left, bounded
    for (int i = 0; i < 200 && expQ.size() != 0; i++) applyStimulus("drain", 1'b0, 4'b0000, 4'd0);
    checks++;
    assert (expQ.size() == 0) else begin
      errors++;
      $error("[TB] FAIL drain_empty observed=%0d expected=0 entries", expQ.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
